serial_add_seq: RTL and testbench
=================================

// Module: serial_add_seq
// PURPOSE
//  Bit-serial adder sequencer; drives one external full_adder cell, LSB first.
//  Latches two WIDTH-bit operands plus carry-in on start.
//  Presents one bit pair and the running carry per cycle to the cell.
//  Shifts the cell's Sum back into a result register.
//  Trades WIDTH+1 cycles of latency for a single 1-bit adder in the datapath.
// PARAMETERS
//  WIDTH   8   operand/result width in bits (>=2)
// PORTS
//  clk      in   1      single clock, all state on rising edge
//  rst_n    in   1      asynchronous, active-low reset
//  start    in   1      request; sampled only in IDLE
//  a        in   WIDTH  operand A, captured when start accepted
//  b        in   WIDTH  operand B, captured when start accepted
//  cin      in   1      carry-in, captured when start accepted
//  busy     out  1      high in SHIFT and DONE
//  done     out  1      1-cycle pulse: sum/cout valid
//  sum      out  WIDTH  registered result, held until next done
//  cout     out  1      registered carry-out, held until next done
//  fa_a     out  1      to full_adder A
//  fa_b     out  1      to full_adder B
//  fa_cin   out  1      to full_adder Cin
//  fa_sum   in   1      from full_adder Sum (combinational path)
//  fa_cout  in   1      from full_adder Cout (combinational path)
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - state=IDLE; all shift regs, carry_q and bit count cleared.
//   - Outputs busy, done, sum, cout, fa_a, fa_b, fa_cin all 0.
//  FSM IDLE -> SHIFT -> DONE -> IDLE.
//  IDLE:
//   - On start=1: load a_sr=a, b_sr=b, carry_q=cin, cnt=0; go SHIFT.
//  SHIFT:
//   - fa_a=a_sr[0], fa_b=b_sr[0], fa_cin=carry_q, driven from registers.
//   - Each edge: res_sr={fa_sum,res_sr[WIDTH-1:1]}; carry_q=fa_cout.
//   - Same edge: a_sr, b_sr shift right by 1; cnt++.
//   - Exit on cnt==WIDTH-1: sum<=final res_sr, cout<=fa_cout; go DONE.
//  DONE: done=1 for exactly one cycle, then IDLE.
//  Latency:
//   - start sampled at edge 0 -> done high in cycle after edge WIDTH+1.
//   - Next start accepted no earlier than the edge at which done is high.
//  fa_a/fa_b/fa_cin are 0 outside SHIFT.
//  start while busy (SHIFT or DONE): ignored, no queuing, operands untouched.
//  a/b/cin may change freely after acceptance.
//  Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1).
//  Reset mid-operation: aborts; no done pulse; sum/cout cleared to 0.
// CONFIGURATION
//  OVERFLOW_FLAG_EN defined:
//   - Adds output port ovf (1 bit): signed overflow, carry into MSB ^ cout.
//   - Carry into MSB = fa_cin on the final SHIFT cycle.
//   - ovf is registered with sum and held until next done; reset value 0.
//  Not defined: no ovf port, no extra logic.
// TESTING (WIDTH=8)
//  a=0x5A b=0x3C cin=0 -> sum=0x96 cout=0; done exactly 9 edges after start.
//  a=0xFF b=0x01 cin=0 -> sum=0x00 cout=1; a=0xFF b=0xFF cin=1 -> sum=0xFF cout=1.
//  start pulsed mid-SHIFT with new a/b -> ignored; first result intact, one done.
//  rst_n low at bit 4 -> busy/done/sum/cout=0 at once; new start -> correct result.
//  Back-to-back: start held high -> results every 10 cycles, done one cycle each.
//  OVERFLOW_FLAG_EN: 0x7F+0x01 -> sum=0x80 ovf=1; 0xFF+0x01 -> ovf=0, cout=1.

Source files
------------

// File: rtl/serial_add_seq.sv
// serial_add_seq: bit-serial adder sequencer.
// Drives one external full_adder cell LSB first. Each cycle it presents one
// operand bit pair plus the running carry, then shifts the cell's sum back
// into a result register. A WIDTH-bit add takes WIDTH+1 cycles from start
// acceptance to the done pulse.
//
// Optional feature: define OVERFLOW_FLAG_EN to add the `ovf` output. `ovf` is
// the signed-overflow flag, computed as (carry into MSB) ^ cout. It is
// registered together with sum/cout.
//
// Handshake: start is a level request that is sampled only while the
// sequencer is idle. Requests seen while busy are dropped rather than queued.
// done is a single-cycle pulse. sum/cout (and ovf) change only on the edge
// that raises done, and hold their values until the next done. The next start
// is accepted at the edge that ends the done cycle at the earliest, so a start
// held high produces one result every WIDTH+2 cycles.
module serial_add_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
`ifdef OVERFLOW_FLAG_EN
    output logic             ovf,
`endif
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_cin,
    input  logic             fa_sum,
    input  logic             fa_cout
);

    // Bit counter must reach WIDTH-1; WIDTH >= 2 keeps CNT_W >= 1.
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic             carry_q;
    logic [CNT_W-1:0] cnt;
    logic             in_shift;

`ifdef OVERFLOW_FLAG_EN
    // Overflow of the final bit step, kept until the result is published.
    logic             ovf_pend;
`endif

    // The cell inputs come straight from the operand/carry registers, gated
    // to zero outside SHIFT so the cell sees a quiet bus when idle.
    assign in_shift = (state == SHIFT);
    assign fa_a     = in_shift & a_sr[0];
    assign fa_b     = in_shift & b_sr[0];
    assign fa_cin   = in_shift & carry_q;

    // Sequencer FSM: holds the operand shifters, the result shifter, the carry and the published outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            a_sr    <= '0;
            b_sr    <= '0;
            res_sr  <= '0;
            carry_q <= 1'b0;
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
`ifdef OVERFLOW_FLAG_EN
            ovf_pend <= 1'b0;
            ovf      <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    // A done pulse lasts only the one idle cycle after DONE.
                    done <= 1'b0;
                    if (start) begin
                        a_sr    <= a;
                        b_sr    <= b;
                        carry_q <= cin;
                        res_sr  <= '0;
                        cnt     <= '0;
                        busy    <= 1'b1;
                        state   <= SHIFT;
                    end
                end

                SHIFT: begin
                    // One bit per edge: consume the LSB pair, collect the sum bit at the top.
                    res_sr  <= {fa_sum, res_sr[WIDTH-1:1]};
                    carry_q <= fa_cout;
                    a_sr    <= {1'b0, a_sr[WIDTH-1:1]};
                    b_sr    <= {1'b0, b_sr[WIDTH-1:1]};
                    cnt     <= cnt + 1'b1;
`ifdef OVERFLOW_FLAG_EN
                    // On the MSB step, fa_cin is the carry into the MSB.
                    ovf_pend <= carry_q ^ fa_cout;
`endif
                    if (cnt == LAST_BIT) begin
                        state <= DONE;
                    end
                end

                DONE: begin
                    // Publish the result together with the done pulse, then release busy.
                    sum   <= res_sr;
                    cout  <= carry_q;
`ifdef OVERFLOW_FLAG_EN
                    ovf   <= ovf_pend;
`endif
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_seq.sv
// tb_serial_add_seq: directed vector table plus multi-cycle corner sequences
// for the bit-serial adder sequencer. The bench models the external full
// adder cell itself.
module tb_serial_add_seq;

    localparam int WIDTH = 8;
    localparam int LAT   = WIDTH + 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic             cin_i;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             fa_a;
    logic             fa_b;
    logic             fa_cin;
    logic             fa_sum;
    logic             fa_cout;
`ifdef OVERFLOW_FLAG_EN
    logic             ovf;
`endif

    int errors = 0;
    int checks = 0;
    int done_seen = 0;

    // Clock / reset block
    always #5 clk = ~clk;

    // External full adder cell
    assign fa_sum  = fa_a ^ fa_b ^ fa_cin;
    assign fa_cout = (fa_a & fa_b) | (fa_a & fa_cin) | (fa_b & fa_cin);

    serial_add_seq #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a_i),
        .b       (b_i),
        .cin     (cin_i),
        .busy    (busy),
        .done    (done),
        .sum     (sum),
        .cout    (cout),
`ifdef OVERFLOW_FLAG_EN
        .ovf     (ovf),
`endif
        .fa_a    (fa_a),
        .fa_b    (fa_b),
        .fa_cin  (fa_cin),
        .fa_sum  (fa_sum),
        .fa_cout (fa_cout)
    );

    // Count every done cycle seen at the sampling edge.
    always @(negedge clk) begin
        if (rst_n && done) done_seen++;
    end

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             cin;
        logic [WIDTH-1:0] sum;
        logic             cout;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Driver: issue one start at a negedge and wait for done. If intrude_at > 1,
    // a second start with different operands is pulsed at that negedge.
    task automatic run_op(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                          input logic vc, input int intrude_at,
                          output logic [WIDTH-1:0] rs, output logic rc, output int lat);
        @(negedge clk);
        a_i = va; b_i = vb; cin_i = vc; start = 1'b1;
        lat = -1;
        rs = '0;
        rc = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (done) begin
                lat = n - 1;
                rs  = sum;
                rc  = cout;
                break;
            end
            if (n == 2) check("busy_in_shift", 32'(busy), 32'd1);
            if (n == intrude_at) begin
                start = 1'b1; a_i = 8'hFF; b_i = 8'hFF; cin_i = 1'b1;
            end else begin
                start = 1'b0;
                // Operands may change freely after acceptance.
                a_i = 8'h00; b_i = 8'h00; cin_i = 1'b0;
            end
        end
        start = 1'b0;
        if (lat < 0) check("done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        logic [WIDTH-1:0] rs;
        logic             rc;
        int               lat;
        int               d0;
        int               exp_pos;

        vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        vecs[4] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
        vecs[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
        vecs[6] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};
        vecs[7] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1};
        vecs[8] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};
        vecs[9] = '{8'h0F, 8'hF0, 1'b0, 8'hFF, 1'b0};

        rst_n = 1'b0; start = 1'b0; a_i = '0; b_i = '0; cin_i = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        check("rst_fa", {29'd0, fa_a, fa_b, fa_cin}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Table-driven vectors
        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].cin, -1, rs, rc, lat);
            check($sformatf("vec%0d_sum", i), 32'(rs), 32'(vecs[i].sum));
            check($sformatf("vec%0d_cout", i), 32'(rc), 32'(vecs[i].cout));
            check($sformatf("vec%0d_lat", i), 32'(lat), 32'(LAT));
            @(negedge clk);
            check($sformatf("vec%0d_done_1cyc", i), 32'(done), 32'd0);
            check($sformatf("vec%0d_sum_hold", i), 32'(sum), 32'(vecs[i].sum));
            check($sformatf("vec%0d_fa_idle", i), {29'd0, fa_a, fa_b, fa_cin}, 32'd0);
        end

        // Start mid-SHIFT with new operands is ignored
        d0 = done_seen;
        run_op(8'h5A, 8'h3C, 1'b0, 4, rs, rc, lat);
        check("ign_sum", 32'(rs), 32'h96);
        check("ign_cout", 32'(rc), 32'd0);
        check("ign_lat", 32'(lat), 32'(LAT));
        repeat (15) @(negedge clk);
        check("ign_one_done", 32'(done_seen - d0), 32'd1);
        check("ign_sum_hold", 32'(sum), 32'h96);

        // Reset while bit 4 is in flight
        @(negedge clk);
        a_i = 8'h33; b_i = 8'h44; cin_i = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_sum", 32'(sum), 32'd0);
        check("mid_rst_cout", 32'(cout), 32'd0);
        d0 = done_seen;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check("mid_rst_no_done", 32'(done_seen - d0), 32'd0);
        run_op(8'hAA, 8'h55, 1'b0, -1, rs, rc, lat);
        check("post_rst_sum", 32'(rs), 32'hFF);
        check("post_rst_cout", 32'(rc), 32'd0);
        check("post_rst_lat", 32'(lat), 32'(LAT));

        // Back-to-back with start held high: one done every LAT+1 cycles
        @(negedge clk);
        a_i = 8'hC8; b_i = 8'h64; cin_i = 1'b1; start = 1'b1;
        d0 = 0;
        exp_pos = LAT + 1;
        for (int n = 1; n <= 35; n++) begin
            @(negedge clk);
            if (done) begin
                d0++;
                check("b2b_pos", 32'(n), 32'(exp_pos));
                check("b2b_sum", 32'(sum), 32'h2D);
                check("b2b_cout", 32'(cout), 32'd1);
                exp_pos = exp_pos + LAT + 1;
            end
        end
        start = 1'b0;
        check("b2b_count", 32'(d0), 32'd3);
        repeat (15) @(negedge clk);

`ifdef OVERFLOW_FLAG_EN
        run_op(8'h7F, 8'h01, 1'b0, -1, rs, rc, lat);
        check("ovf_pos_sum", 32'(rs), 32'h80);
        check("ovf_pos_flag", 32'(ovf), 32'd1);
        @(negedge clk);
        check("ovf_hold", 32'(ovf), 32'd1);
        run_op(8'hFF, 8'h01, 1'b0, -1, rs, rc, lat);
        check("ovf_neg_cout", 32'(rc), 32'd1);
        check("ovf_neg_flag", 32'(ovf), 32'd0);
        @(negedge clk);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
